// File: rtl/aes_leak_monitor.sv
// Leakage monitor beside an AES core: counts start/done handshakes, flags
// side-bus observations that reproduce the loaded key, and reports protocol errors.
module aes_leak_monitor #(
  parameter int unsigned KEY_W        = 128,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned TIMEOUT      = 64,
  parameter int unsigned MATCH_THRESH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [KEY_W-1:0] key_i,
  input  logic             key_load_i,
  input  logic             start_i,
  input  logic             done_i,
  input  logic             obs_valid_i,
  input  logic [KEY_W-1:0] obs_data_i,
  input  logic             clear_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] enc_count_o,
  output logic             leak_alarm_o,
  output logic [7:0]       leak_hits_o,
  output logic [CNT_W-1:0] first_leak_idx_o,
  output logic             timeout_err_o,
  output logic             proto_err_o
);

  localparam int unsigned NBYTES = KEY_W / 8;
  localparam int unsigned MW     = $clog2(NBYTES + 1);
  localparam int unsigned TW     = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state;
  logic [KEY_W-1:0]  key_q;
  logic              key_valid;
  logic [TW-1:0]     timer;
  logic [MW-1:0]     matches_c;
  logic              hit_c;

  // Byte-wise key match count against the key held before any same-cycle load
  always_comb begin
    matches_c = '0;
    for (int b = 0; b < NBYTES; b++) begin
      if (obs_data_i[8*b +: 8] == key_q[8*b +: 8]) matches_c = matches_c + MW'(1);
    end
    hit_c = obs_valid_i && key_valid && (matches_c >= MW'(MATCH_THRESH));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state            <= IDLE;
      key_q            <= '0;
      key_valid        <= 1'b0;
      timer            <= '0;
      busy_o           <= 1'b0;
      enc_count_o      <= '0;
      leak_alarm_o     <= 1'b0;
      leak_hits_o      <= '0;
      first_leak_idx_o <= '0;
      timeout_err_o    <= 1'b0;
      proto_err_o      <= 1'b0;
    end else if (clear_i) begin
      state            <= IDLE;
      key_q            <= '0;
      key_valid        <= 1'b0;
      timer            <= '0;
      busy_o           <= 1'b0;
      enc_count_o      <= '0;
      leak_alarm_o     <= 1'b0;
      leak_hits_o      <= '0;
      first_leak_idx_o <= '0;
      timeout_err_o    <= 1'b0;
      proto_err_o      <= 1'b0;
    end else begin
      // Leak path is independent of the handshake FSM
      if (hit_c) begin
        leak_alarm_o <= 1'b1;
        if (leak_hits_o != 8'hFF) leak_hits_o <= leak_hits_o + 8'd1;
        if (!leak_alarm_o) first_leak_idx_o <= enc_count_o;
      end

      case (state)
        IDLE: begin
          if (key_load_i) begin
            key_q     <= key_i;
            key_valid <= 1'b1;
          end
          if (done_i) proto_err_o <= 1'b1;
          if (start_i) begin
            state  <= BUSY;
            busy_o <= 1'b1;
            timer  <= '0;
          end
        end
        BUSY: begin
          if (key_load_i || start_i) proto_err_o <= 1'b1;
          // A done on the last allowed cycle still completes normally
          if (done_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
            if (enc_count_o != CNT_MAX) enc_count_o <= enc_count_o + CNT_W'(1);
          end else if (timer == TW'(TIMEOUT - 1)) begin
            state         <= IDLE;
            busy_o        <= 1'b0;
            timeout_err_o <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_leak_monitor.sv
// Directed bench for aes_leak_monitor: long handshake run, leak thresholds,
// timeout, protocol table and asynchronous reset mid-transaction.
module tb_aes_leak_monitor;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] key;
  logic         key_load, start, done, obs_valid, clear;
  logic [127:0] obs;

  logic         busy, alarm, tout, proto;
  logic [15:0]  enc, idx;
  logic [7:0]   hits;
  logic         busy12, alarm12, tout12, proto12;
  logic [15:0]  enc12, idx12;
  logic [7:0]   hits12;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [127:0] K  = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] NK = ~K;

  always #5 clk = ~clk;

  aes_leak_monitor dut (
    .clk_i(clk), .rst_i(rst), .key_i(key), .key_load_i(key_load),
    .start_i(start), .done_i(done), .obs_valid_i(obs_valid), .obs_data_i(obs),
    .clear_i(clear), .busy_o(busy), .enc_count_o(enc), .leak_alarm_o(alarm),
    .leak_hits_o(hits), .first_leak_idx_o(idx), .timeout_err_o(tout),
    .proto_err_o(proto)
  );

  aes_leak_monitor #(.MATCH_THRESH(12)) dut12 (
    .clk_i(clk), .rst_i(rst), .key_i(key), .key_load_i(key_load),
    .start_i(start), .done_i(done), .obs_valid_i(obs_valid), .obs_data_i(obs),
    .clear_i(clear), .busy_o(busy12), .enc_count_o(enc12), .leak_alarm_o(alarm12),
    .leak_hits_o(hits12), .first_leak_idx_o(idx12), .timeout_err_o(tout12),
    .proto_err_o(proto12)
  );

  typedef struct {
    logic         kl;
    logic [127:0] k;
    logic         st, dn, ov;
    logic [127:0] o;
    logic         clr;
    logic         e_busy;
    logic [15:0]  e_enc;
    logic         e_alarm;
    logic [7:0]   e_hits;
    logic [15:0]  e_idx;
    logic         e_tout, e_proto;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic b, input logic [15:0] e,
                         input logic a, input logic [7:0] h, input logic [15:0] i,
                         input logic t, input logic p);
    chk({tag, ".busy"},  32'(busy),  32'(b));
    chk({tag, ".enc"},   32'(enc),   32'(e));
    chk({tag, ".alarm"}, 32'(alarm), 32'(a));
    chk({tag, ".hits"},  32'(hits),  32'(h));
    chk({tag, ".idx"},   32'(idx),   32'(i));
    chk({tag, ".tout"},  32'(tout),  32'(t));
    chk({tag, ".proto"}, 32'(proto), 32'(p));
  endtask

  task automatic handshake();
    start = 1'b1; cyc(); start = 1'b0;
    repeat (9) cyc();
    done = 1'b1; cyc(); done = 1'b0;
  endtask

  initial begin
    int cnt;
    rst = 1'b1; key = '0; key_load = 0; start = 0; done = 0;
    obs_valid = 0; obs = '0; clear = 0;
    cyc(); cyc();
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // Load key, 999 clean handshakes with non-matching observations
    key = K; key_load = 1; cyc(); key_load = 0;
    obs_valid = 1; obs = NK;
    for (int i = 0; i < 999; i++) handshake();
    chk_all("run999", 0, 999, 0, 0, 0, 0, 0);

    // 1000th handshake, then leak observations
    handshake();
    obs = K; cyc(); obs_valid = 0; obs = NK;
    chk_all("leak1", 0, 1000, 1, 1, 1000, 0, 0);
    obs_valid = 1; obs = K; cyc(); cyc(); obs_valid = 0;
    chk_all("leak3", 0, 1000, 1, 3, 1000, 0, 0);

    // Thresholds and key_valid gating
    clear = 1; cyc(); clear = 0;
    obs_valid = 1; obs = '0; cyc(); obs_valid = 0;
    chk("nokey.alarm16", 32'(alarm), 0);
    chk("nokey.alarm12", 32'(alarm12), 0);
    key = K; key_load = 1; cyc(); key_load = 0;
    obs_valid = 1; obs = K ^ 128'hFF_FFFF_FFFF; cyc();
    chk("m11.alarm16", 32'(alarm), 0);
    chk("m11.alarm12", 32'(alarm12), 0);
    obs = K ^ 128'hFF; cyc(); obs_valid = 0;
    chk("m15.alarm16", 32'(alarm), 0);
    chk("m15.alarm12", 32'(alarm12), 1);
    clear = 1; cyc(); clear = 0;
    key_load = 1; cyc(); key_load = 0;
    obs_valid = 1; obs = K ^ 128'hFFFF_FFFF; cyc(); obs_valid = 0;
    chk("m12.alarm16", 32'(alarm), 0);
    chk("m12.alarm12", 32'(alarm12), 1);
    chk("m12.hits12", 32'(hits12), 1);

    // Timeout: busy for exactly TIMEOUT cycles
    clear = 1; cyc(); clear = 0;
    start = 1; cyc(); start = 0;
    cnt = 0;
    for (int i = 0; i < 200 && busy; i++) begin cnt++; cyc(); end
    chk("tout.busy_cycles", 32'(cnt), 64);
    chk_all("tout", 0, 0, 0, 0, 0, 1, 0);

    // done on the last allowed BUSY cycle wins
    clear = 1; cyc(); clear = 0;
    start = 1; cyc(); start = 0;
    repeat (63) cyc();
    chk("edge.busy", 32'(busy), 1);
    done = 1; cyc(); done = 0;
    chk_all("edge", 0, 1, 0, 0, 0, 0, 0);

    // Protocol and same-cycle-ordering table
    //            kl k  st dn ov o  clr | busy enc al hits idx to pe
    vecs.push_back('{0, 0,  0, 0, 0, 0,  1,  0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 0,  1, 0, 0, 0,  0,  1, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 0,  1, 0, 0, 0,  0,  1, 0, 0, 0, 0, 0, 1});
    vecs.push_back('{0, 0,  0, 0, 0, 0,  1,  0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 0,  0, 1, 0, 0,  0,  0, 0, 0, 0, 0, 0, 1});
    vecs.push_back('{0, 0,  0, 0, 0, 0,  1,  0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 0,  1, 0, 0, 0,  0,  1, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{1, NK, 0, 0, 0, 0,  0,  1, 0, 0, 0, 0, 0, 1});
    vecs.push_back('{0, 0,  0, 1, 0, 0,  0,  0, 1, 0, 0, 0, 0, 1});
    vecs.push_back('{0, 0,  0, 0, 0, 0,  1,  0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 0,  1, 1, 0, 0,  0,  1, 0, 0, 0, 0, 0, 1});
    vecs.push_back('{0, 0,  0, 1, 0, 0,  0,  0, 1, 0, 0, 0, 0, 1});
    vecs.push_back('{0, 0,  1, 0, 0, 0,  0,  1, 1, 0, 0, 0, 0, 1});
    vecs.push_back('{0, 0,  0, 1, 0, 0,  1,  0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{1, K,  0, 0, 0, 0,  0,  0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{1, NK, 0, 0, 1, NK, 0,  0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 0,  0, 0, 1, NK, 0,  0, 0, 1, 1, 0, 0, 0});
    vecs.push_back('{0, 0,  0, 0, 0, 0,  1,  0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{1, K,  0, 0, 0, 0,  0,  0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 0,  1, 0, 0, 0,  0,  1, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 0,  0, 1, 0, 0,  0,  0, 1, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 0,  1, 0, 0, 0,  0,  1, 1, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 0,  0, 1, 1, K,  0,  0, 2, 1, 1, 1, 0, 0});
    vecs.push_back('{0, 0,  0, 0, 1, K,  0,  0, 2, 1, 2, 1, 0, 0});
    for (int i = 0; i < vecs.size(); i++) begin
      key_load = vecs[i].kl; key = vecs[i].k; start = vecs[i].st; done = vecs[i].dn;
      obs_valid = vecs[i].ov; obs = vecs[i].o; clear = vecs[i].clr;
      cyc();
      chk_all($sformatf("vec%0d", i), vecs[i].e_busy, vecs[i].e_enc, vecs[i].e_alarm,
              vecs[i].e_hits, vecs[i].e_idx, vecs[i].e_tout, vecs[i].e_proto);
    end
    key_load = 0; start = 0; done = 0; obs_valid = 0; clear = 0;

    // Asynchronous reset in the middle of BUSY
    start = 1; cyc(); start = 0;
    done = 1; cyc(); cyc(); done = 0;
    start = 1; cyc(); start = 0;
    chk("prerst.busy", 32'(busy), 1);
    #3 rst = 1;
    #1 chk_all("async_rst", 0, 0, 0, 0, 0, 0, 0);
    #1 rst = 0;
    start = 1; cyc(); start = 0;
    done = 1; cyc(); done = 0;
    chk_all("post_rst", 0, 1, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
